// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, sequencer stages, trap causes, access sizes
// and the instruction field/immediate decoder used by the core.
package rv32i_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEMORY, ST_WRITEBACK, ST_TRAP
   } stage_e;

   typedef enum logic [1:0] {
      CAUSE_NONE, CAUSE_ILLEGAL, CAUSE_MIS_LOAD, CAUSE_MIS_STORE
   } cause_e;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic        funct7b5;
      logic [31:0] imm;
   } dec_t;

   function automatic dec_t decode(input logic [31:0] i);
      dec_t d;
      d.opcode   = i[6:0];
      d.rd       = i[11:7];
      d.funct3   = i[14:12];
      d.rs1      = i[19:15];
      d.rs2      = i[24:20];
      d.funct7b5 = i[30];
      case (i[6:0])
         OP_STORE:         d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
         OP_BRANCH:        d.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         OP_JAL:           d.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         OP_LUI, OP_AUIPC: d.imm = {i[31:12], 12'b0};
         default:          d.imm = {{20{i[31]}}, i[31:20]};
      endcase
      return d;
   endfunction

endpackage

// File: rtl/rv32i_core_hs_if.sv
// Instruction and data memory request/acknowledge bus of the handshake core.
interface rv32i_core_hs_if;
   logic [31:0] inst;
   logic        i_ack;
   logic [31:0] iaddr;
   logic        i_req;
   logic [31:0] din;
   logic        d_ack;
   logic        d_req;
   logic [31:0] daddr;
   logic [31:0] dout;
   logic [3:0]  wr_mask;
   logic        wr_en;

   modport master (input inst, i_ack, din, d_ack,
                   output iaddr, i_req, d_req, daddr, dout, wr_mask, wr_en);
   modport slave  (output inst, i_ack, din, d_ack,
                   input iaddr, i_req, d_req, daddr, dout, wr_mask, wr_en);
endinterface

// File: rtl/rv32i_trap_check.sv
// Combinational trap detection: opcode legality and load/store alignment,
// folded into a single cause code (illegal opcode takes priority).
module rv32i_trap_check
   import rv32i_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [1:0] size,
   input  logic [1:0] addr_lo,
   output logic       illegal,
   output logic       misaligned,
   output cause_e     cause
);
   logic is_load, is_store, bad_align;

   assign is_load  = (opcode == OP_LOAD);
   assign is_store = (opcode == OP_STORE);

   always_comb begin
      case (opcode)
         OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
         OP_LUI, OP_AUIPC, OP_SYSTEM, OP_FENCE: illegal = 1'b0;
         default:                               illegal = 1'b1;
      endcase
   end

   always_comb begin
      case (size)
         SZ_WORD: bad_align = (addr_lo != 2'b00);
         SZ_HALF: bad_align = addr_lo[0];
         default: bad_align = 1'b0;
      endcase
   end

   assign misaligned = bad_align && (is_load || is_store);

   always_comb begin
      cause = CAUSE_NONE;
      if (illegal)         cause = CAUSE_ILLEGAL;
      else if (misaligned) cause = is_store ? CAUSE_MIS_STORE : CAUSE_MIS_LOAD;
   end
endmodule

// File: rtl/rv32i_core_hs.sv
// Multi-cycle RV32I core with handshaked instruction/data memory, optional
// MEMORY skip for non-memory ops, trap path and retired-instruction counter.
module rv32i_core_hs
   import rv32i_pkg::*;
#(
   parameter logic [31:0] PC_RESET    = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR = 32'h0000_0004,
   parameter bit          SKIP_MEM    = 1'b1
) (
   input  logic           clk,
   input  logic           rst_n,
   rv32i_core_hs_if.master bus,
   output logic           trap,
   output logic [1:0]     trap_cause,
   output logic [31:0]    instret
);
   stage_e      state, state_nxt;
   logic [31:0] pc, inst_r, alu_r, load_r;
   logic [31:0] rf [32];
   dec_t        d;
   logic        illegal, misaligned, is_load, is_store, is_mem, rd_we, taken;
   logic        i_req, d_req;
   cause_e      cause;
   logic [31:0] rs1v, rs2v, alu_a, alu_b, alu_y, pc4, pc_new, ld_sh, ld_ext, wb_data;

   assign d        = decode(inst_r);
   assign rs1v     = (d.rs1 == 5'd0) ? 32'd0 : rf[d.rs1];
   assign rs2v     = (d.rs2 == 5'd0) ? 32'd0 : rf[d.rs2];
   assign is_load  = (d.opcode == OP_LOAD);
   assign is_store = (d.opcode == OP_STORE);
   assign is_mem   = is_load || is_store;
   assign pc4      = pc + 32'd4;

   rv32i_trap_check u_trap_check (
      .opcode     (d.opcode),
      .size       (d.funct3[1:0]),
      .addr_lo    (alu_r[1:0]),
      .illegal    (illegal),
      .misaligned (misaligned),
      .cause      (cause)
   );

   always_comb begin
      alu_a = (d.opcode == OP_JAL || d.opcode == OP_AUIPC) ? pc : rs1v;
      alu_b = (d.opcode == OP_R || d.opcode == OP_BRANCH) ? rs2v : d.imm;
      alu_y = alu_a + alu_b;
      if (d.opcode == OP_LUI) begin
         alu_y = alu_b;
      end else if (d.opcode == OP_R || d.opcode == OP_I) begin
         case (d.funct3)
            3'b000:  alu_y = (d.opcode == OP_R && d.funct7b5) ? alu_a - alu_b : alu_a + alu_b;
            3'b001:  alu_y = alu_a << alu_b[4:0];
            3'b010:  alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            3'b011:  alu_y = {31'd0, alu_a < alu_b};
            3'b100:  alu_y = alu_a ^ alu_b;
            3'b101:  alu_y = d.funct7b5 ? $unsigned($signed(alu_a) >>> alu_b[4:0])
                                        : alu_a >> alu_b[4:0];
            3'b110:  alu_y = alu_a | alu_b;
            default: alu_y = alu_a & alu_b;
         endcase
      end
   end

   // Operands are still valid in WRITEBACK since the regfile only changes there.
   always_comb begin
      case (d.funct3)
         3'b000:  taken = (rs1v == rs2v);
         3'b001:  taken = (rs1v != rs2v);
         3'b100:  taken = ($signed(rs1v) <  $signed(rs2v));
         3'b101:  taken = ($signed(rs1v) >= $signed(rs2v));
         3'b110:  taken = (rs1v <  rs2v);
         3'b111:  taken = (rs1v >= rs2v);
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      case (d.opcode)
         OP_JAL:    pc_new = alu_r;
         OP_JALR:   pc_new = {alu_r[31:1], 1'b0};
         OP_BRANCH: pc_new = taken ? pc + d.imm : pc4;
         default:   pc_new = pc4;
      endcase
   end

   always_comb begin
      ld_sh = load_r >> {alu_r[1:0], 3'b000};
      case (d.funct3[1:0])
         SZ_BYTE: ld_ext = {{24{~d.funct3[2] & ld_sh[7]}},  ld_sh[7:0]};
         SZ_HALF: ld_ext = {{16{~d.funct3[2] & ld_sh[15]}}, ld_sh[15:0]};
         default: ld_ext = ld_sh;
      endcase
      case (d.opcode)
         OP_LOAD:         wb_data = ld_ext;
         OP_JAL, OP_JALR: wb_data = pc4;
         default:         wb_data = alu_r;
      endcase
      case (d.opcode)
         OP_R, OP_I, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: rd_we = (d.rd != 5'd0);
         default:                                                rd_we = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_FETCH;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_FETCH:     if (bus.i_ack) state_nxt = ST_DECODE;
         ST_DECODE:    state_nxt = illegal ? ST_TRAP : ST_EXECUTE;
         ST_EXECUTE:   state_nxt = (is_mem || !SKIP_MEM) ? ST_MEMORY : ST_WRITEBACK;
         ST_MEMORY: begin
            if (!is_mem)         state_nxt = ST_WRITEBACK;
            else if (misaligned) state_nxt = ST_TRAP;
            else if (bus.d_ack)  state_nxt = ST_WRITEBACK;
         end
         default:      state_nxt = ST_FETCH;
      endcase
   end

   always_comb begin
      i_req       = (state == ST_FETCH);
      d_req       = (state == ST_MEMORY) && is_mem && !misaligned;
      trap        = (state == ST_TRAP);
      bus.i_req   = i_req;
      bus.d_req   = d_req;
      bus.wr_en   = d_req && is_store;
      bus.iaddr   = pc;
      bus.daddr   = alu_r;
      bus.dout    = rs2v << {alu_r[1:0], 3'b000};
      case (d.funct3[1:0])
         SZ_BYTE: bus.wr_mask = 4'b0001 << alu_r[1:0];
         SZ_HALF: bus.wr_mask = 4'b0011 << alu_r[1:0];
         default: bus.wr_mask = 4'b1111;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc         <= PC_RESET;
         inst_r     <= 32'd0;
         alu_r      <= 32'd0;
         load_r     <= 32'd0;
         instret    <= 32'd0;
         trap_cause <= CAUSE_NONE;
      end else begin
         case (state)
            ST_FETCH:     if (bus.i_ack) inst_r <= bus.inst;
            ST_EXECUTE:   alu_r <= alu_y;
            ST_MEMORY:    if (d_req && bus.d_ack && is_load) load_r <= bus.din;
            ST_WRITEBACK: begin
               pc      <= pc_new;
               instret <= instret + 32'd1;
            end
            ST_TRAP:      pc <= TRAP_VECTOR;
            default:      ;
         endcase
         if (state_nxt == ST_TRAP && state != ST_TRAP) trap_cause <= cause;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && state == ST_WRITEBACK && rd_we) rf[d.rd] <= wb_data;
   end
endmodule
